// File: rtl/rggen_bus_exporter_mc.sv
// Multi-channel register-bus exporter: forwards one local command to one of CHANNELS external buses.
// Define RGGEN_BUS_EXPORTER_TIMEOUT_EN to add a response timeout after TIMEOUT_CYCLES request cycles.
module rggen_bus_exporter_mc #(
    parameter int DATA_WIDTH             = 32,
    parameter int LOCAL_ADDRESS_WIDTH    = 8,
    parameter int EXTERNAL_ADDRESS_WIDTH = 7,
    parameter int CHANNELS               = 2,
    parameter logic [CHANNELS*LOCAL_ADDRESS_WIDTH-1:0] START_ADDRESSES = '0,
    parameter int TIMEOUT_CYCLES         = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    input  logic [CHANNELS-1:0]               i_select,
    input  logic                              i_write,
    input  logic                              i_read,
    input  logic [LOCAL_ADDRESS_WIDTH-1:0]    i_address,
    input  logic [DATA_WIDTH/8-1:0]           i_strobe,
    input  logic [DATA_WIDTH-1:0]             i_write_data,
    output logic                              o_ready,
    output logic [DATA_WIDTH-1:0]             o_read_data,
    output logic [1:0]                        o_status,
    output logic [CHANNELS-1:0]               o_valid,
    output logic                              o_write,
    output logic                              o_read,
    output logic [EXTERNAL_ADDRESS_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH/8-1:0]           o_strobe,
    output logic [DATA_WIDTH-1:0]             o_write_data,
    input  logic [CHANNELS-1:0]               i_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]    i_read_data,
    input  logic [CHANNELS*2-1:0]             i_status
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    generate
        if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
            $error("CHANNELS must be within 1..16");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RESPONSE
    } state_e;

    state_e                              state;
    logic [CH_W-1:0]                     ch;
    logic [CH_W-1:0]                     sel_index;
    logic [LOCAL_ADDRESS_WIDTH-1:0]      sel_start;
    logic [EXTERNAL_ADDRESS_WIDTH-1:0]   rebased;
    logic                                ch_ready;
    logic [1:0]                          ch_status;
    logic [DATA_WIDTH-1:0]               ch_read_data;
    logic                                timeout_hit;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_index = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (i_select[k]) begin
                sel_index = CH_W'(k);
            end
        end
        sel_start    = START_ADDRESSES[sel_index*LOCAL_ADDRESS_WIDTH +: LOCAL_ADDRESS_WIDTH];
        rebased      = EXTERNAL_ADDRESS_WIDTH'(i_address - sel_start);
        ch_ready     = i_ready[ch];
        ch_status    = i_status[ch*2 +: 2];
        ch_read_data = i_read_data[ch*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef RGGEN_BUS_EXPORTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;

    // The limit fires on the cycle whose increment would reach TIMEOUT_CYCLES.
    assign timeout_hit = (state == REQUEST) && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == IDLE) begin
            timer <= '0;
        end else if (state == REQUEST && !ch_ready) begin
            timer <= timer + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ch           <= '0;
            o_ready      <= 1'b0;
            o_read_data  <= '0;
            o_status     <= 2'b00;
            o_valid      <= '0;
            o_write      <= 1'b0;
            o_read       <= 1'b0;
            o_address    <= '0;
            o_strobe     <= '0;
            o_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && |i_select) begin
                        state        <= REQUEST;
                        ch           <= sel_index;
                        o_valid      <= CHANNELS'(1) << sel_index;
                        o_write      <= i_write;
                        o_read       <= i_read;
                        o_address    <= rebased;
                        o_strobe     <= i_strobe;
                        o_write_data <= i_write_data;
                    end
                end
                REQUEST: begin
                    if (ch_ready) begin
                        state       <= RESPONSE;
                        o_valid     <= '0;
                        o_write     <= 1'b0;
                        o_read      <= 1'b0;
                        o_ready     <= 1'b1;
                        o_status    <= ch_status;
                        o_read_data <= o_read ? ch_read_data : '0;
                    end else if (timeout_hit) begin
                        state       <= RESPONSE;
                        o_valid     <= '0;
                        o_write     <= 1'b0;
                        o_read      <= 1'b0;
                        o_ready     <= 1'b1;
                        o_status    <= 2'b10;
                        o_read_data <= '0;
                    end
                end
                RESPONSE: begin
                    o_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rggen_bus_exporter_mc.sv
// Directed, table-driven bench for rggen_bus_exporter_mc (CHANNELS=2, windows at 8'h80 and 8'hC0).
// Expected values are hand-computed; RGGEN_BUS_EXPORTER_TIMEOUT_EN selects the timeout sequence.
module tb_rggen_bus_exporter_mc;
    localparam int DW  = 32;
    localparam int LAW = 8;
    localparam int EAW = 7;
    localparam int CH  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_valid;
    logic [CH-1:0]   i_select;
    logic            i_write;
    logic            i_read;
    logic [LAW-1:0]  i_address;
    logic [DW/8-1:0] i_strobe;
    logic [DW-1:0]   i_write_data;
    logic            o_ready;
    logic [DW-1:0]   o_read_data;
    logic [1:0]      o_status;
    logic [CH-1:0]   o_valid;
    logic            o_write;
    logic            o_read;
    logic [EAW-1:0]  o_address;
    logic [DW/8-1:0] o_strobe;
    logic [DW-1:0]   o_write_data;
    logic [CH-1:0]   i_ready;
    logic [CH*DW-1:0] i_read_data;
    logic [CH*2-1:0] i_status;

    int tests = 0;
    int fails = 0;

    rggen_bus_exporter_mc #(
        .DATA_WIDTH            (DW),
        .LOCAL_ADDRESS_WIDTH   (LAW),
        .EXTERNAL_ADDRESS_WIDTH(EAW),
        .CHANNELS              (CH),
        .START_ADDRESSES       ({8'hC0, 8'h80}),
        .TIMEOUT_CYCLES        (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_select    (i_select),
        .i_write     (i_write),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_strobe    (i_strobe),
        .i_write_data(i_write_data),
        .o_ready     (o_ready),
        .o_read_data (o_read_data),
        .o_status    (o_status),
        .o_valid     (o_valid),
        .o_write     (o_write),
        .o_read      (o_read),
        .o_address   (o_address),
        .o_strobe    (o_strobe),
        .o_write_data(o_write_data),
        .i_ready     (i_ready),
        .i_read_data (i_read_data),
        .i_status    (i_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0]   sel;
        logic            write;
        logic [LAW-1:0]  addr;
        logic [DW/8-1:0] strobe;
        logic [DW-1:0]   wdata;
        int              wait_cycles;
        logic            poke_other;
        logic [DW-1:0]   rd0;
        logic [DW-1:0]   rd1;
        logic [1:0]      st0;
        logic [1:0]      st1;
        logic [CH-1:0]   exp_valid;
        logic [EAW-1:0]  exp_addr;
        logic [DW-1:0]   exp_rdata;
        logic [1:0]      exp_status;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid      = 1'b0;
        i_select     = '0;
        i_write      = 1'b0;
        i_read       = 1'b0;
        i_address    = '0;
        i_strobe     = '0;
        i_write_data = '0;
        i_ready      = '0;
    endtask

    // One full transaction: accept, hold for wait_cycles, then a single-cycle ready on the chosen channel.
    task automatic run_vec(input vec_t v, input int idx);
        logic [CH-1:0] others;
        int            unstable;
        others       = ~v.exp_valid;
        unstable     = 0;
        i_valid      = 1'b1;
        i_select     = v.sel;
        i_write      = v.write;
        i_read       = ~v.write;
        i_address    = v.addr;
        i_strobe     = v.strobe;
        i_write_data = v.wdata;
        i_read_data  = {v.rd1, v.rd0};
        i_status     = {v.st1, v.st0};
        step();
        i_valid = 1'b0;
        i_select = '0;
        check($sformatf("v%0d req valid", idx), 64'(o_valid), 64'(v.exp_valid));
        check($sformatf("v%0d req addr", idx), 64'(o_address), 64'(v.exp_addr));
        check($sformatf("v%0d req wr/rd/strb", idx), 64'({o_write, o_read, o_strobe}),
              64'({v.write, ~v.write, v.strobe}));
        check($sformatf("v%0d req wdata", idx), 64'(o_write_data), 64'(v.wdata));
        for (int w = 0; w < v.wait_cycles; w++) begin
            i_ready = v.poke_other ? others : '0;
            step();
            if (o_valid !== v.exp_valid || o_address !== v.exp_addr || o_strobe !== v.strobe ||
                o_write_data !== v.wdata || o_ready !== 1'b0)
                unstable++;
        end
        if (v.wait_cycles > 0)
            check($sformatf("v%0d hold unstable cycles", idx), 64'(unstable), 64'd0);
        i_ready = v.exp_valid;
        step();
        i_ready = '0;
        check($sformatf("v%0d rsp ready/valid/wr/rd", idx), 64'({o_ready, o_valid, o_write, o_read}),
              64'({1'b1, 2'b00, 1'b0, 1'b0}));
        check($sformatf("v%0d rsp rdata", idx), 64'(o_read_data), 64'(v.exp_rdata));
        check($sformatf("v%0d rsp status", idx), 64'(o_status), 64'(v.exp_status));
        step();
        check($sformatf("v%0d post ready/rdata/status", idx), {31'd0, o_ready, o_read_data},
              {31'd0, 1'b0, v.exp_rdata});
        check($sformatf("v%0d post status hold", idx), 64'(o_status), 64'(v.exp_status));
    endtask

    initial begin
        int bad;
        //           sel    wr    addr   strb     wdata         wait poke rd0            rd1            st0    st1    exp_v  exp_a  exp_rdata      exp_st
        vecs[0] = '{2'b01, 1'b0, 8'h84, 4'hF, 32'h0,         0, 1'b0, 32'hDEADBEEF, 32'h0,         2'b00, 2'b00, 2'b01, 7'h04, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{2'b10, 1'b1, 8'hC8, 4'h3, 32'h12345678,  5, 1'b0, 32'h0,         32'hFFFFFFFF,  2'b00, 2'b00, 2'b10, 7'h08, 32'h0,        2'b00};
        vecs[2] = '{2'b11, 1'b0, 8'h90, 4'hF, 32'h0,         2, 1'b1, 32'hA5A50001, 32'h0BAD0BAD,  2'b01, 2'b11, 2'b01, 7'h10, 32'hA5A50001, 2'b01};
        vecs[3] = '{2'b10, 1'b0, 8'hC0, 4'hF, 32'h0,         1, 1'b1, 32'h99999999, 32'h11112222,  2'b00, 2'b10, 2'b10, 7'h00, 32'h11112222, 2'b10};
        vecs[4] = '{2'b10, 1'b0, 8'h7F, 4'hF, 32'h0,         0, 1'b0, 32'h0,         32'hCAFEF00D,  2'b00, 2'b11, 2'b10, 7'h3F, 32'hCAFEF00D, 2'b11};
        vecs[5] = '{2'b01, 1'b1, 8'h00, 4'h8, 32'hFEEDFACE,  3, 1'b1, 32'h55555555, 32'h0,         2'b01, 2'b00, 2'b01, 7'h00, 32'h0,        2'b01};

        idle_inputs();
        i_read_data = '0;
        i_status    = '0;
        rst = 1'b1;
        #12;
        check("reset outputs", 64'({o_ready, o_valid, o_write, o_read, o_status, o_address, o_strobe}), 64'd0);
        check("reset data", {o_read_data, o_write_data}, 64'd0);
        #5 rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Valid with no window selected must be ignored.
        bad = 0;
        i_valid = 1'b1; i_select = '0; i_read = 1'b1; i_address = 8'h84; i_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            step();
            if (o_valid !== 2'b00 || o_ready !== 1'b0) bad++;
        end
        idle_inputs();
        check("no-select ignored", 64'(bad), 64'd0);

        // Held command with zero-wait slave: accepted every 3 cycles, ignored during RESPONSE.
        i_valid = 1'b1; i_select = 2'b01; i_read = 1'b1; i_address = 8'h88; i_ready = 2'b01;
        i_read_data = {32'h0, 32'h0000ABCD}; i_status = 4'b0000;
        step();
        check("b2b c1 valid", 64'({o_valid, o_address}), 64'({2'b01, 7'h08}));
        step();
        check("b2b c2 ready", 64'({o_ready, o_valid}), 64'({1'b1, 2'b00}));
        step();
        check("b2b c3 idle", 64'({o_ready, o_valid}), 64'd0);
        step();
        check("b2b c4 valid again", 64'(o_valid), 64'(2'b01));
        step();
        i_valid = 1'b0;
        check("b2b c5 ready", 64'({o_ready, o_read_data}), {31'd0, 1'b1, 32'h0000ABCD});
        step();
        idle_inputs();
        check("b2b c6 idle", 64'({o_ready, o_valid}), 64'd0);

        // Reset in REQUEST drops o_valid asynchronously and suppresses any response.
        i_valid = 1'b1; i_select = 2'b01; i_read = 1'b1; i_address = 8'h84;
        step();
        i_valid = 1'b0; i_select = '0;
        check("pre-reset valid", 64'(o_valid), 64'(2'b01));
        #2 rst = 1'b1;
        #1;
        check("async reset valid", 64'(o_valid), 64'd0);
        step();
        #3 rst = 1'b0;
        bad = 0;
        i_ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            step();
            if (o_ready !== 1'b0 || o_valid !== 2'b00) bad++;
        end
        i_ready = '0;
        check("no response after reset", 64'(bad), 64'd0);
        run_vec(vecs[0], 10);

`ifdef RGGEN_BUS_EXPORTER_TIMEOUT_EN
        // Slave never answers: o_valid for 4 cycles, then SLVERR with zero data.
        bad = 0;
        i_read_data = {32'h0, 32'h77777777}; i_status = 4'b0000;
        i_valid = 1'b1; i_select = 2'b01; i_read = 1'b1; i_address = 8'h84;
        step();
        i_valid = 1'b0; i_select = '0;
        for (int c = 0; c < 4; c++) begin
            if (o_valid !== 2'b01 || o_ready !== 1'b0) bad++;
            step();
        end
        check("timeout valid window", 64'(bad), 64'd0);
        check("timeout response", 64'({o_ready, o_valid, o_status}), 64'({1'b1, 2'b00, 2'b10}));
        check("timeout rdata", 64'(o_read_data), 64'd0);
        step();
        i_ready = 2'b01;
        step();
        i_ready = '0;
        check("late ready ignored", 64'({o_ready, o_valid}), 64'd0);
        step();
        check("late ready ignored 2", 64'({o_ready, o_status}), 64'(2'b10));
`else
        // Without the timeout the request waits indefinitely.
        bad = 0;
        i_read_data = {32'h0, 32'h77777777}; i_status = 4'b0001;
        i_valid = 1'b1; i_select = 2'b01; i_read = 1'b1; i_address = 8'h84;
        step();
        i_valid = 1'b0; i_select = '0;
        for (int c = 0; c < 1000; c++) begin
            if (o_valid !== 2'b01 || o_ready !== 1'b0) bad++;
            step();
        end
        check("no-timeout wait", 64'(bad), 64'd0);
        i_ready = 2'b01;
        step();
        i_ready = '0;
        check("no-timeout response", 64'({o_ready, o_status, o_read_data}), {29'd0, 1'b1, 2'b01, 32'h77777777});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rggen_bus_exporter_mc.md
Name: rggen_bus_exporter_mc

Overview:
- Multi-channel successor of the single-region external bus exporter.
- Bridges one local register-bus command to one of CHANNELS external buses, each owning its own address window.
- Sits between the per-window address decoders/response mux and the external slaves.
- Adds registered request/response sequencing, per-channel address rebasing and an optional response timeout.

Parameters:
- DATA_WIDTH, 32: local and external data width.
- LOCAL_ADDRESS_WIDTH, 8: local byte-address width.
- EXTERNAL_ADDRESS_WIDTH, 7: external byte-address width, shared by all channels.
- CHANNELS, 2: number of external buses (1..16).
- START_ADDRESSES, {CHANNELS{8'h00}}: flattened start byte address per channel; channel k is at bits [k*LOCAL_ADDRESS_WIDTH +: LOCAL_ADDRESS_WIDTH].
- TIMEOUT_CYCLES, 256: REQUEST-state cycle limit. Used only with the optional feature; must be ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  local command valid; held by the host until o_ready
- i_select  in  CHANNELS  one-hot window select from the address decoders
- i_write  in  1  write command
- i_read  in  1  read command
- i_address  in  LOCAL_ADDRESS_WIDTH  local byte address
- i_strobe  in  DATA_WIDTH/8  byte strobes
- i_write_data  in  DATA_WIDTH  write data
- o_ready  out  1  one-cycle response pulse to the response mux
- o_read_data  out  DATA_WIDTH  response read data
- o_status  out  2  response status: 00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR
- o_valid  out  CHANNELS  per-channel external request valid
- o_write  out  1  external write, shared by all channels
- o_read  out  1  external read, shared by all channels
- o_address  out  EXTERNAL_ADDRESS_WIDTH  rebased address
- o_strobe  out  DATA_WIDTH/8  external strobes
- o_write_data  out  DATA_WIDTH  external write data
- i_ready  in  CHANNELS  per-channel external ready
- i_read_data  in  CHANNELS*DATA_WIDTH  flattened per-channel read data
- i_status  in  CHANNELS*2  flattened per-channel status

Behaviour:
- FSM states: IDLE, REQUEST, RESPONSE. Reset value is IDLE.
- Reset values: all outputs 0; channel index 0; timeout counter 0.
- Reset asserted mid-transaction aborts immediately: o_valid drops asynchronously and no response is produced.
- IDLE → REQUEST when i_valid && |i_select.
  - Latch channel ch = index of the lowest set bit of i_select. Multiple set bits are not an error; the lowest wins.
  - Latch write, read, strobe and write_data.
  - Latch o_address = (i_address - START_ADDRESSES[ch]) truncated to EXTERNAL_ADDRESS_WIDTH (modulo wrap).
- i_valid with i_select == 0 is ignored; the FSM stays in IDLE.
- REQUEST:
  - o_valid[ch] = 1; all other o_valid bits are 0.
  - o_write and o_read are the latched values; both are 0 outside REQUEST.
  - Address, strobe and write data stay stable until i_ready[ch].
  - i_ready on non-selected channels is ignored.
- REQUEST → RESPONSE on i_ready[ch].
  - Capture o_status = i_status[ch].
  - Capture o_read_data = i_read_data[ch] for reads; 0 for writes.
- RESPONSE: o_ready = 1 for exactly one cycle, then → IDLE. i_valid is ignored in this cycle.
- o_read_data and o_status hold their values until the next capture.
- Latency with a zero-wait slave:
  - cycle 0: i_valid sampled
  - cycle 1: o_valid high, i_ready high
  - cycle 2: o_ready high
- Back-to-back: a new command can be accepted in the cycle after RESPONSE. Minimum spacing is 3 cycles per transaction.
- A command arriving while not in IDLE is not accepted; the host holds it.

Optional Feature:
- Macro: RGGEN_BUS_EXPORTER_TIMEOUT_EN.
- Defined:
  - A counter clears on REQUEST entry and increments each REQUEST cycle without i_ready[ch].
  - When the counter reaches TIMEOUT_CYCLES, go to RESPONSE with o_status = 2'b10 and o_read_data = 0, dropping o_valid[ch].
  - If i_ready[ch] arrives in the same cycle the limit is reached, i_ready wins and the normal response is returned.
  - Any late i_ready on that channel after a timeout is ignored.
- Undefined: no counter; REQUEST waits indefinitely.

Test Plan:
- CHANNELS=2, START_ADDRESSES={8'hC0,8'h80}.
  - Read at 8'h84 with i_select=2'b01 and a zero-wait slave returning 32'hDEADBEEF/00.
  - → o_valid=01, o_address=7'h04, o_ready at cycle 2, o_read_data=DEADBEEF, o_status=00.
- Write at 8'hC8, strobe 4'b0011, data 32'h1234_5678, channel-1 ready after 5 cycles.
  - → o_valid=10 held 6 cycles, o_address=7'h08, outputs stable throughout.
  - → o_ready 1 cycle later, o_read_data=0.
- i_select=2'b11 → channel 0 chosen. i_ready[1] pulses during REQUEST → ignored.
- rst pulsed in REQUEST → o_valid=0 immediately, no o_ready. The next command completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=4), slave never ready.
  - → o_valid drops after 4 cycles, o_status=10, o_read_data=0.
  - A later i_ready is ignored.
- Macro undefined, same stimulus → o_valid stays high for 1000 cycles, no o_ready.
